arb_rr_n: RTL and testbench

- Parametrised N-requester bus arbiter for shared-memory access. Generalises the two-master DMA/TDSP arbiter to N_REQ masters.
- Runtime-selectable fixed-priority or round-robin policy.
- Optional hold-time preemption and a configurable bus turnaround (CLEAR) period.
- Sits between the bus masters and the memory controller. Grants are registered and one-hot, so they are glitch-free.

---
 rtl/arb_pkg.sv | 20 ++
 rtl/arb_pick.sv | 36 +++
 rtl/arb_rr_n.sv | 134 +++++++++++++
 tb/tb_arb_rr_n.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and width helpers for the N-requester bus arbiter.
// Index and counter widths never collapse to zero bits.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    CLEAR = 2'd2
  } state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // hold_cnt must reach HOLD_MAX itself, hence clog2(HOLD_MAX+1)
  function automatic int cnt_w(input int max_val);
    return (max_val > 0) ? $clog2(max_val + 1) : 1;
  endfunction

endpackage

// File: rtl/arb_pick.sv
// Combinational winner search: rotate candidates so the search start sits at bit 0,
// priority-encode the lowest set bit, then rotate the index back.
module arb_pick
  import arb_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]        cand,
  input  logic [idx_w(N_REQ)-1:0] rr_ptr,
  input  logic                    mode_rr,
  output logic                    found,
  output logic [idx_w(N_REQ)-1:0] winner
);

  localparam int IW = idx_w(N_REQ);
  localparam logic [IW:0] N_W = (IW + 1)'(N_REQ);

  logic [IW-1:0]    ptr;
  logic [N_REQ-1:0] rot;
  logic [IW-1:0]    off;
  logic [IW:0]      sum;

  always_comb begin
    ptr   = mode_rr ? rr_ptr : '0;
    rot   = N_REQ'({cand, cand} >> ptr);
    found = |rot;
    off   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = IW'(i);
    end
    sum = {1'b0, off} + {1'b0, ptr};
    if (sum >= N_W) sum = sum - N_W;
    winner = sum[IW-1:0];
  end

endmodule

// File: rtl/arb_rr_n.sv
// N-requester bus arbiter: fixed-priority or round-robin, hold-time preemption,
// and a grant-free turnaround period after every release. All outputs registered.
module arb_rr_n
  import arb_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int HOLD_MAX     = 16,
  parameter int CLEAR_CYCLES = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req,
  input  logic                    mode_rr,
  output logic [N_REQ-1:0]        grant,
  output logic                    grant_valid,
  output logic [idx_w(N_REQ)-1:0] grant_id,
  output logic                    preempt
);

  localparam int IW = idx_w(N_REQ);
  localparam int HW = cnt_w(HOLD_MAX);
  localparam int CW = cnt_w(CLEAR_CYCLES);
  localparam logic [HW-1:0]    HOLD_LIM = HW'(HOLD_MAX);
  localparam logic [CW-1:0]    CLR_LIM  = CW'(CLEAR_CYCLES);
  localparam logic [IW-1:0]    LAST_IDX = IW'(N_REQ - 1);
  localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ - 1){1'b0}}, 1'b1};

  state_t           state, nxt_state;
  logic [HW-1:0]    hold_cnt, nxt_hold;
  logic [CW-1:0]    clr_cnt, nxt_clr;
  logic [N_REQ-1:0] mask, nxt_mask;
  logic [IW-1:0]    rr_ptr, nxt_ptr;
  logic [N_REQ-1:0] nxt_grant;
  logic             nxt_gv;
  logic [IW-1:0]    nxt_id;
  logic             nxt_pre;

  logic             found;
  logic [IW-1:0]    winner;
  logic             do_arb;
  logic             holder_req;
  logic             other_req;

  arb_pick #(.N_REQ(N_REQ)) u_pick (
    .cand    (req & ~mask),
    .rr_ptr  (rr_ptr),
    .mode_rr (mode_rr),
    .found   (found),
    .winner  (winner)
  );

  // grant is one-hot, so masking req with it isolates the holder's request
  assign holder_req = |(req & grant);
  assign other_req  = |(req & ~grant);

  always_comb begin
    nxt_state = state;
    nxt_hold  = hold_cnt;
    nxt_clr   = clr_cnt;
    nxt_mask  = mask;
    nxt_ptr   = rr_ptr;
    nxt_grant = grant;
    nxt_gv    = grant_valid;
    nxt_id    = grant_id;
    nxt_pre   = 1'b0;
    do_arb    = 1'b0;

    case (state)
      IDLE: do_arb = 1'b1;
      GRANT: begin
        if (!holder_req) begin
          nxt_state = CLEAR;
          nxt_grant = '0;
          nxt_gv    = 1'b0;
          nxt_clr   = CW'(1);
        end else if ((HOLD_MAX > 0) && (hold_cnt == HOLD_LIM) && other_req) begin
          nxt_state = CLEAR;
          nxt_grant = '0;
          nxt_gv    = 1'b0;
          nxt_clr   = CW'(1);
          nxt_pre   = 1'b1;
          nxt_mask  = grant;
        end else if (hold_cnt < HOLD_LIM) begin
          nxt_hold = hold_cnt + HW'(1);
        end
      end
      CLEAR: begin
        if (clr_cnt == CLR_LIM) do_arb = 1'b1;
        else nxt_clr = clr_cnt + CW'(1);
      end
      default: nxt_state = IDLE;
    endcase

    // The mask only ever shields one arbitration, whether or not anyone wins it
    if (do_arb) begin
      nxt_mask = '0;
      if (found) begin
        nxt_state = GRANT;
        nxt_grant = ONE_HOT0 << winner;
        nxt_gv    = 1'b1;
        nxt_id    = winner;
        nxt_hold  = HW'(1);
        nxt_ptr   = (winner == LAST_IDX) ? '0 : winner + IW'(1);
      end else begin
        nxt_state = IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      hold_cnt    <= '0;
      clr_cnt     <= '0;
      mask        <= '0;
      rr_ptr      <= '0;
      grant       <= '0;
      grant_valid <= 1'b0;
      grant_id    <= '0;
      preempt     <= 1'b0;
    end else begin
      state       <= nxt_state;
      hold_cnt    <= nxt_hold;
      clr_cnt     <= nxt_clr;
      mask        <= nxt_mask;
      rr_ptr      <= nxt_ptr;
      grant       <= nxt_grant;
      grant_valid <= nxt_gv;
      grant_id    <= nxt_id;
      preempt     <= nxt_pre;
    end
  end

endmodule

// File: tb/tb_arb_rr_n.sv
// Directed bench for arb_rr_n (N_REQ=4, HOLD_MAX=8, CLEAR_CYCLES=1) with a
// bus-ownership model compared every cycle plus hand-computed literal checks.
module tb_arb_rr_n;

  localparam int N  = 4;
  localparam int HM = 8;
  localparam int CC = 1;

  logic       clk;
  logic       reset;
  logic [3:0] req;
  logic       mode_rr;
  logic [3:0] grant;
  logic       grant_valid;
  logic [1:0] grant_id;
  logic       preempt;

  int total = 0;
  int bad   = 0;
  bit cmp_en = 1'b0;

  arb_rr_n #(.N_REQ(N), .HOLD_MAX(HM), .CLEAR_CYCLES(CC)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .mode_rr     (mode_rr),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id),
    .preempt     (preempt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model of bus ownership: who owns the bus, for how long, how many quiet
  // cycles remain, who is barred from the next pick, where the rotation resumes.
  int m_owner = -1;
  int m_held  = 0;
  int m_quiet = 0;
  int m_ban   = -1;
  int m_start = 0;
  int m_id    = 0;
  bit m_pre   = 1'b0;

  function automatic int choose(input logic [3:0] r, input int ban, input int start, input bit rr);
    for (int k = 0; k < N; k++) begin
      int j;
      j = rr ? (start + k) % N : k;
      if (r[j] && j != ban) return j;
    end
    return -1;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_owner = -1; m_held = 0; m_quiet = 0; m_ban = -1; m_start = 0; m_id = 0; m_pre = 1'b0;
    end else begin
      m_pre = 1'b0;
      if (m_owner >= 0) begin
        if (!req[m_owner]) begin
          m_owner = -1;
          m_quiet = CC;
        end else if (HM > 0 && m_held >= HM && (req & ~(4'b0001 << m_owner)) != 4'b0000) begin
          m_ban   = m_owner;
          m_owner = -1;
          m_quiet = CC;
          m_pre   = 1'b1;
        end else begin
          m_held++;
        end
      end else if (m_quiet > 1) begin
        m_quiet--;
      end else begin
        int w;
        w       = choose(req, m_ban, m_start, mode_rr);
        m_ban   = -1;
        m_quiet = 0;
        if (w >= 0) begin
          m_owner = w;
          m_held  = 1;
          m_id    = w;
          m_start = (w + 1) % N;
        end
      end
    end
  end

  logic [3:0] e_grant;
  always @(negedge clk) begin
    if (cmp_en) begin
      e_grant = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
      chk("model_grant", grant, e_grant);
      chk("model_grant_valid", grant_valid, m_owner >= 0);
      chk("model_grant_id", grant_id, m_id);
      chk("model_preempt", preempt, m_pre);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  int n_own0;
  int n_pre;
  bit saw1;

  initial begin
    reset = 1'b0; req = 4'b0000; mode_rr = 1'b0;
    #1 reset = 1'b1;
    @(negedge clk);
    cmp_en = 1'b1;
    chk("reset_grant", grant, 4'b0000);
    chk("reset_grant_valid", grant_valid, 1'b0);
    chk("reset_grant_id", grant_id, 2'd0);
    chk("reset_preempt", preempt, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    tick(2);

    // single requester
    req = 4'b0100;
    @(negedge clk);
    chk("single_grant_first", grant, 4'b0100);
    chk("single_id", grant_id, 2'd2);
    tick(3);
    chk("single_grant_edge4", grant, 4'b0100);
    req = 4'b0000;
    @(negedge clk);
    chk("single_release", grant, 4'b0000);
    @(negedge clk);
    chk("single_idle_valid", grant_valid, 1'b0);
    chk("single_id_held", grant_id, 2'd2);
    tick(1);

    // fixed priority, holder re-raises during turnaround and wins again
    req = 4'b1010;
    @(negedge clk);
    chk("fixed_first", grant, 4'b0010);
    tick(2);
    req = 4'b1000;
    @(negedge clk);
    chk("fixed_clear", grant, 4'b0000);
    req = 4'b1010;
    @(negedge clk);
    chk("fixed_regrant", grant, 4'b0010);
    chk("fixed_regrant_id", grant_id, 2'd1);
    req = 4'b0000;
    tick(3);

    // hold-time preemption
    req = 4'b0011;
    n_own0 = 0; n_pre = 0; saw1 = 1'b0;
    for (int c = 0; c < 20 && !saw1; c++) begin
      @(negedge clk);
      if (grant == 4'b0001) n_own0++;
      if (preempt) n_pre++;
      if (grant == 4'b0010) saw1 = 1'b1;
    end
    chk("preempt_hold_cycles", n_own0, HM);
    chk("preempt_pulses", n_pre, 1);
    chk("preempt_next_owner", grant, 4'b0010);
    req = 4'b0000;
    tick(3);

    // asynchronous reset mid-grant
    mode_rr = 1'b1;
    req = 4'b0100;
    @(negedge clk);
    chk("rst_pre_grant", grant, 4'b0100);
    #2 reset = 1'b1;
    #1;
    chk("rst_async_grant", grant, 4'b0000);
    chk("rst_async_valid", grant_valid, 1'b0);
    chk("rst_async_preempt", preempt, 1'b0);
    req = 4'b1111;
    @(negedge clk);
    reset = 1'b0;

    // round-robin fairness from pointer 0
    for (int k = 0; k < 5; k++) begin
      logic [3:0] exp_g;
      exp_g = 4'b0001 << (k % 4);
      @(negedge clk);
      chk("rr_grant", grant, exp_g);
      @(negedge clk);
      req = 4'b1111 & ~exp_g;
      @(negedge clk);
      chk("rr_gap", grant, 4'b0000);
      req = 4'b1111;
    end
    req = 4'b0000;
    tick(3);

    // sole masked requester after a forced preemption
    mode_rr = 1'b0;
    req = 4'b0001;
    @(negedge clk);
    chk("mask_first", grant, 4'b0001);
    tick(7);
    chk("mask_hold8", grant, 4'b0001);
    req = 4'b0011;
    @(negedge clk);
    chk("mask_preempt", preempt, 1'b1);
    chk("mask_clear", grant, 4'b0000);
    req = 4'b0001;
    @(negedge clk);
    chk("mask_idle", grant, 4'b0000);
    @(negedge clk);
    chk("mask_regrant", grant, 4'b0001);
    req = 4'b0000;
    tick(3);

    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
